mac32_dot_sequencer: RTL and testbench

Sequential controller that time-multiplexes the combinational MAC32 datapath (Result = A + B*C) to compute an FP32 dot product with accumulation: acc = init + sum(b[k]*c[k]), k = 0..len-1. It accepts operand pairs over a valid/ready stream and registers B/C into operand registers. It feeds the running accumulator back as A, and captures the MAC result one cycle later. It sits between an operand source (DMA/FIFO) and an externally instantiated MAC32 datapath.

---
 rtl/mac32_dot_sequencer_if.sv | 28 ++
 rtl/mac32_dot_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mac32_dot_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac32_dot_sequencer_if.sv
// Operand stream and MAC datapath bus for mac32_dot_sequencer.
//   b_i/c_i/in_valid_i/in_ready_o : operand-pair valid/ready stream (source -> sequencer)
//   mac_a_o/mac_b_o/mac_c_o       : operands presented to the external MAC (A + B*C)
//   mac_result_i                  : combinational MAC result returned to the sequencer
// Signal names are seen from the sequencer; the slave modport is the sequencer side,
// the master modport is the source/MAC side.
interface mac32_dot_sequencer_if #(
    parameter int unsigned PARM_XLEN = 32
);
    logic [PARM_XLEN-1:0] b_i;
    logic [PARM_XLEN-1:0] c_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [PARM_XLEN-1:0] mac_a_o;
    logic [PARM_XLEN-1:0] mac_b_o;
    logic [PARM_XLEN-1:0] mac_c_o;
    logic [PARM_XLEN-1:0] mac_result_i;

    modport slave (
        input  b_i, c_i, in_valid_i, mac_result_i,
        output in_ready_o, mac_a_o, mac_b_o, mac_c_o
    );

    modport master (
        output b_i, c_i, in_valid_i, mac_result_i,
        input  in_ready_o, mac_a_o, mac_b_o, mac_c_o
    );
endinterface

// File: rtl/mac32_dot_sequencer.sv
// FP32 dot-product sequencer around an external combinational MAC (Result = A + B*C).
// Computes acc = init + sum(b[k]*c[k]) for k = 0..len-1, one pair every two cycles.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   start_i            : start request, honoured only in IDLE
//   len_i, init_i      : vector length and initial accumulator, sampled with start_i
//   bus_io (slave)     : operand stream b/c valid/ready and MAC operand/result bus
//   busy_o, done_o     : run in progress, one-cycle completion pulse
//   acc_o, count_o     : accumulator and pairs accumulated so far
//   nan_o, inf_o       : sticky flags, an accumulator write was NaN / Inf
module mac32_dot_sequencer #(
    parameter int unsigned PARM_XLEN  = 32,
    parameter int unsigned PARM_EXP   = 8,
    parameter int unsigned PARM_MANT  = 23,
    parameter int unsigned PARM_LEN_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [PARM_LEN_W-1:0] len_i,
    input  logic [PARM_XLEN-1:0]  init_i,
    mac32_dot_sequencer_if.slave  bus_io,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [PARM_XLEN-1:0]  acc_o,
    output logic [PARM_LEN_W-1:0] count_o,
    output logic                  nan_o,
    output logic                  inf_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StExec, StDone} state_e;

    state_e state_q, state_d;

    logic [PARM_XLEN-1:0]  acc_q, acc_d;
    logic [PARM_XLEN-1:0]  b_q, b_d;
    logic [PARM_XLEN-1:0]  c_q, c_d;
    logic [PARM_LEN_W-1:0] len_q, len_d;
    logic [PARM_LEN_W-1:0] count_q, count_d;
    logic                  nan_q, nan_d;
    logic                  inf_q, inf_d;

    // One extra bit so count+1 == len compares cleanly at len = 2^PARM_LEN_W-1.
    logic [PARM_LEN_W:0] count_inc;
    logic                last_pair;
    logic [PARM_EXP-1:0] res_exp;
    logic [PARM_MANT-1:0] res_mant;
    logic                res_nan;
    logic                res_inf;

    assign count_inc = {1'b0, count_q} + 1'b1;
    assign last_pair = (count_inc == {1'b0, len_q});
    assign res_exp   = bus_io.mac_result_i[PARM_MANT +: PARM_EXP];
    assign res_mant  = bus_io.mac_result_i[PARM_MANT-1:0];
    assign res_nan   = (&res_exp) && (res_mant != '0);
    assign res_inf   = (&res_exp) && (res_mant == '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (bus_io.in_valid_i) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = last_pair ? StDone : StLoad;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus_io.in_ready_o = (state_q == StLoad);
        busy_o            = (state_q != StIdle);
        done_o            = (state_q == StDone);
    end

    // Datapath next-state
    always_comb begin
        acc_d   = acc_q;
        b_d     = b_q;
        c_d     = c_q;
        len_d   = len_q;
        count_d = count_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d   = len_i;
                    acc_d   = init_i;
                    count_d = '0;
                    nan_d   = 1'b0;
                    inf_d   = 1'b0;
                end
            end
            StLoad: begin
                if (bus_io.in_valid_i) begin
                    b_d = bus_io.b_i;
                    c_d = bus_io.c_i;
                end
            end
            StExec: begin
                acc_d   = bus_io.mac_result_i;
                count_d = count_inc[PARM_LEN_W-1:0];
                if (res_nan) begin
                    nan_d = 1'b1;
                end
                if (res_inf) begin
                    inf_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            b_q     <= '0;
            c_q     <= '0;
            len_q   <= '0;
            count_q <= '0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            b_q     <= b_d;
            c_q     <= c_d;
            len_q   <= len_d;
            count_q <= count_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
        end
    end

    assign bus_io.mac_a_o = acc_q;
    assign bus_io.mac_b_o = b_q;
    assign bus_io.mac_c_o = c_q;

    assign acc_o   = acc_q;
    assign count_o = count_q;
    assign nan_o   = nan_q;
    assign inf_o   = inf_q;

endmodule

// File: tb/tb_mac32_dot_sequencer.sv
// Self-checking bench for mac32_dot_sequencer: directed vector table, hand-written
// reset/start corner sequences, and randomized runs against a dot-product model.
// The external MAC is modelled here via real arithmetic (truncating to FP32).
module tb_mac32_dot_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [31:0] init;
    logic        busy, done, nan, inf;
    logic [31:0] acc;
    logic [7:0]  count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] pb[$];
    logic [31:0] pc[$];

    localparam logic [31:0] JUNK = 32'h40A00000;

    mac32_dot_sequencer_if #(.PARM_XLEN(32)) bus ();

    mac32_dot_sequencer #(
        .PARM_XLEN(32), .PARM_EXP(8), .PARM_MANT(23), .PARM_LEN_W(8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .len_i   (len),
        .init_i  (init),
        .bus_io  (bus),
        .busy_o  (busy),
        .done_o  (done),
        .acc_o   (acc),
        .count_o (count),
        .nan_o   (nan),
        .inf_o   (inf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- MAC model ----------------
    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 0) return $bitstoreal(64'h7FF8000000000000);
            return $bitstoreal({x[31], 11'h7FF, 52'h0});
        end
        if (x[30:23] == 8'h00) return $bitstoreal({x[31], 63'h0});
        e = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'h7FF) return (d[51:0] != 0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'h0};
        if (e >= 11'd1151) return {d[63], 8'hFF, 23'h0};
        if (e <= 11'd896) return {d[63], 31'h0};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] mac_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        return r2f(f2r(a) + f2r(b) * f2r(c));
    endfunction

    always_comb bus.mac_result_i = mac_fn(bus.mac_a_o, bus.mac_b_o, bus.mac_c_o);

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one accumulation using pb/pc; stall = idle LOAD cycles before each pair.
    // Entered and left one time unit after a rising edge.
    task automatic run_seq(input string tag, input logic [7:0] n, input logic [31:0] ini,
                           input int stall, input logic [31:0] exp_acc,
                           input logic exp_nan, input logic exp_inf, input int exp_lat);
        int t, idx, left, rdy_cyc, lat;
        bit seen;
        start = 1'b1;
        len   = n;
        init  = ini;
        bus.in_valid_i = 1'b1;
        bus.b_i = JUNK;
        bus.c_i = JUNK;
        t = cyc;
        tick();
        start = 1'b0;
        idx = 0; left = stall; rdy_cyc = 0; seen = 1'b0; lat = 0;
        for (int k = 0; k < 600 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
                lat  = cyc - t;
            end else begin
                if (bus.in_ready_o) begin
                    rdy_cyc++;
                    if (left > 0) begin
                        bus.in_valid_i = 1'b0;
                        left--;
                    end else begin
                        bus.in_valid_i = 1'b1;
                        bus.b_i = (idx < pb.size()) ? pb[idx] : JUNK;
                        bus.c_i = (idx < pc.size()) ? pc[idx] : JUNK;
                        idx++;
                        left = stall;
                    end
                end else begin
                    // Offered outside LOAD: must not be consumed.
                    bus.in_valid_i = 1'b1;
                    bus.b_i = JUNK;
                    bus.c_i = JUNK;
                end
                tick();
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, " acc"}, acc, exp_acc);
            chk({tag, " count"}, 32'(count), 32'(n));
            chk({tag, " nan"}, 32'(nan), 32'(exp_nan));
            chk({tag, " inf"}, 32'(inf), 32'(exp_inf));
            chk({tag, " ready_cycles"}, 32'(rdy_cyc), 32'(int'(n) * (stall + 1)));
            chk({tag, " pairs_sent"}, 32'(idx), 32'(n));
        end
        bus.in_valid_i = 1'b0;
        tick();
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
        chk({tag, " acc_hold"}, acc, exp_acc);
        chk({tag, " nan_hold"}, 32'(nan), 32'(exp_nan));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [7:0]       len;
        logic [31:0]      init;
        logic [3:0][31:0] b;
        logic [3:0][31:0] c;
        int               stall;
        logic [31:0]      acc;
        logic             nan;
        logic             inf;
        int               lat;
    } vec_t;

    vec_t tbl[5];

    task automatic set_vec(input int i, input logic [7:0] n, input logic [31:0] ini,
                           input logic [31:0] b0, input logic [31:0] c0,
                           input logic [31:0] b1, input logic [31:0] c1,
                           input logic [31:0] b2, input logic [31:0] c2, input int stall,
                           input logic [31:0] a, input logic na, input logic in,
                           input int lat);
        tbl[i].len = n;   tbl[i].init = ini;
        tbl[i].b[0] = b0; tbl[i].c[0] = c0;
        tbl[i].b[1] = b1; tbl[i].c[1] = c1;
        tbl[i].b[2] = b2; tbl[i].c[2] = c2;
        tbl[i].b[3] = 0;  tbl[i].c[3] = 0;
        tbl[i].stall = stall; tbl[i].acc = a;
        tbl[i].nan = na; tbl[i].inf = in; tbl[i].lat = lat;
    endtask

    initial begin
        int t, dcount, seen;
        logic [31:0] racc;
        logic rn, ri;
        logic [7:0] rlen;
        int rstall;

        set_vec(0, 8'd2, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                32'h40800000, 0, 0, 0, 32'h41600000, 1'b0, 1'b0, 5);
        set_vec(1, 8'd0, 32'h40490FDB, 0, 0, 0, 0, 0, 0, 0, 32'h40490FDB, 1'b0, 1'b0, 1);
        set_vec(2, 8'd3, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000,
                32'h40000000, 32'h40000000, 32'h40000000, 4, 32'h41500000, 1'b0, 1'b0, 19);
        set_vec(3, 8'd2, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h7FC00000,
                32'h3F800000, 0, 0, 0, 32'h7FC00000, 1'b1, 1'b0, 5);
        set_vec(4, 8'd1, 32'h00000000, 32'h7F000000, 32'h7F000000, 0, 0, 0, 0, 0,
                32'h7F800000, 1'b0, 1'b1, 3);

        rst = 1'b1; start = 1'b0; len = 0; init = 0;
        bus.in_valid_i = 1'b0; bus.b_i = 0; bus.c_i = 0;
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(bus.in_ready_o), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst acc", acc, 32'd0);
        chk("rst count", 32'(count), 32'd0);
        chk("rst flags", {30'd0, nan, inf}, 32'd0);
        chk("rst mac_b", bus.mac_b_o, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            pb.delete();
            pc.delete();
            for (int k = 0; k < int'(tbl[i].len); k++) begin
                pb.push_back(tbl[i].b[k]);
                pc.push_back(tbl[i].c[k]);
            end
            run_seq($sformatf("vec%0d", i), tbl[i].len, tbl[i].init, tbl[i].stall,
                    tbl[i].acc, tbl[i].nan, tbl[i].inf, tbl[i].lat);
        end

        // Reset during EXEC of pair 2 of 4: abort without done.
        start = 1'b1; len = 8'd4; init = 32'h3F800000;
        bus.in_valid_i = 1'b1; bus.b_i = 32'h3F800000; bus.c_i = 32'h3F800000;
        tick();                 // LOAD
        start = 1'b0;
        tick();                 // EXEC pair 1
        tick();                 // LOAD
        tick();                 // EXEC pair 2
        chk("abort in_exec", {30'd0, busy, bus.in_ready_o}, 32'd2);
        chk("abort count1", 32'(count), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort acc", acc, 32'd0);
        chk("abort count", 32'(count), 32'd0);
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dcount++;
            tick();
        end
        chk("abort no_done", 32'(dcount), 32'd0);
        bus.in_valid_i = 1'b0;
        pb.delete(); pc.delete();
        pb.push_back(32'h3F800000); pc.push_back(32'h3F800000);
        run_seq("after_abort", 8'd1, 32'h00000000, 0, 32'h3F800000, 1'b0, 1'b0, 3);

        // start_i held high across a whole len=1 run.
        start = 1'b1; len = 8'd1; init = 32'h00000000;
        bus.in_valid_i = 1'b1; bus.b_i = 32'h3F800000; bus.c_i = 32'h40000000;
        t = cyc; dcount = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) dcount++;
        end
        chk("held idle_t4", {31'd0, busy}, 32'd0);
        chk("held one_done", 32'(dcount), 32'd1);
        chk("held acc", acc, 32'h40000000);
        tick();
        chk("held restart", {31'd0, busy}, 32'd1);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            tick();
            if (done) seen = cyc - t;
        end
        chk("held second_done_at", 32'(seen), 32'd7);
        bus.in_valid_i = 1'b0;
        tick();

        // Randomized runs against the dot-product model.
        for (int r = 0; r < 16; r++) begin
            rlen   = 8'($urandom_range(1, 6));
            rstall = int'($urandom_range(0, 2));
            racc   = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
            init   = racc;
            pb.delete(); pc.delete();
            rn = 1'b0; ri = 1'b0;
            for (int k = 0; k < int'(rlen); k++) begin
                pb.push_back({1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)});
                pc.push_back({1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)});
                racc = mac_fn(racc, pb[k], pc[k]);
                if (racc[30:23] == 8'hFF) begin
                    if (racc[22:0] != 0) rn = 1'b1;
                    else ri = 1'b1;
                end
            end
            run_seq($sformatf("rnd%0d", r), rlen, init, rstall, racc, rn, ri,
                    2 * int'(rlen) + 1 + rstall * int'(rlen));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
